// File: rtl/regfile_wb_scheduler.sv
// Scoreboard plus writeback arbiter in front of register_bank: blocks issue on RAW/WAW
// hazards and round-robins the single bank write port between the ALU and memory results.
module regfile_wb_scheduler #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic [$clog2(NREG)-1:0]  issue_rs1,
   input  logic [$clog2(NREG)-1:0]  issue_rs2,
   input  logic [$clog2(NREG)-1:0]  issue_rd,
   output logic                     issue_ready,
   input  logic                     alu_valid,
   input  logic [$clog2(NREG)-1:0]  alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [$clog2(NREG)-1:0]  mem_rd,
   input  logic [XLEN-1:0]          mem_data,
   output logic                     mem_ready,
   output logic                     we,
   output logic [$clog2(NREG)-1:0]  ain,
   output logic [XLEN-1:0]          din,
   output logic [NREG-1:0]          busy,
   output logic                     wb_err
);
   localparam int AW = $clog2(NREG);

   typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

   grant_t            last_grant_reg, last_grant_next;
   logic [NREG-1:0]   busy_reg, busy_next;
   logic              we_reg, we_next;
   logic [AW-1:0]     ain_reg, ain_next;
   logic [XLEN-1:0]   din_reg, din_next;
   logic              wb_err_reg, wb_err_next;

   logic              grant_alu, grant_mem, any_grant, issue_fire;
   logic [AW-1:0]     win_rd;
   logic [XLEN-1:0]   win_data;

   assign issue_ready = !busy_reg[issue_rs1] && !busy_reg[issue_rs2] && !busy_reg[issue_rd];
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

   // On a tie the requester that did not win last time gets the port.
   assign grant_alu = alu_valid && (!mem_valid || (last_grant_reg == GRANT_MEM));
   assign grant_mem = mem_valid && !grant_alu;
   assign any_grant = grant_alu || grant_mem;
   assign win_rd    = grant_alu ? alu_rd   : mem_rd;
   assign win_data  = grant_alu ? alu_data : mem_data;

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   always_comb begin
      last_grant_next = last_grant_reg;
      we_next         = 1'b0;
      ain_next        = ain_reg;
      din_next        = din_reg;
      wb_err_next     = wb_err_reg;
      if (any_grant) begin
         last_grant_next = grant_alu ? GRANT_ALU : GRANT_MEM;
         we_next         = (win_rd != '0);
         ain_next        = win_rd;
         din_next        = win_data;
         if ((win_rd != '0) && !busy_reg[win_rd])
            wb_err_next = 1'b1;
      end
   end

   // Per-register scoreboard bit; a new producer wins over a retiring write to the same index.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_busy
         if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
         end else begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic set_hit, clr_hit;
            assign set_hit       = issue_fire && (issue_rd == IDX);
            assign clr_hit       = we_reg && (ain_reg == IDX);
            assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_reg <= GRANT_MEM;
         busy_reg       <= '0;
         we_reg         <= 1'b0;
         ain_reg        <= '0;
         din_reg        <= '0;
         wb_err_reg     <= 1'b0;
      end else begin
         last_grant_reg <= last_grant_next;
         busy_reg       <= busy_next;
         we_reg         <= we_next;
         ain_reg        <= ain_next;
         din_reg        <= din_next;
         wb_err_reg     <= wb_err_next;
      end
   end

   assign we     = we_reg;
   assign ain    = ain_reg;
   assign din    = din_reg;
   assign busy   = busy_reg;
   assign wb_err = wb_err_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: table-driven hazard checks, directed
// corner sequences, and randomized traffic against an event-level scoreboard model.
module tb_regfile_wb_scheduler;
   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic              issue_valid;
   logic [4:0]        issue_rs1, issue_rs2, issue_rd;
   logic              issue_ready;
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [4:0]        mem_rd;
   logic [XLEN-1:0]   mem_data;
   logic              mem_ready;
   logic              we;
   logic [4:0]        ain;
   logic [XLEN-1:0]   din;
   logic [NREG-1:0]   busy;
   logic              wb_err;

   regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_ready(issue_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .we(we), .ain(ain), .din(din), .busy(busy), .wb_err(wb_err)
   );

   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issue_one(input logic [4:0] rd);
      issue_valid = 1'b1; issue_rs1 = '0; issue_rs2 = '0; issue_rd = rd;
      tick();
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       exp_ready;
   } rdy_vec_t;

   rdy_vec_t tbl[8];

   // Reference model: scoreboard as a set of pending registers, one-cycle write pipe.
   bit              m_busy[NREG];
   bit              m_we;
   logic [4:0]      m_ain;
   logic [XLEN-1:0] m_din;
   bit              m_err;
   bit              m_alu_won_last;

   function automatic logic [NREG-1:0] model_busy_vec();
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      m_we = 1'b0; m_ain = '0; m_din = '0; m_err = 1'b0;
      m_alu_won_last = 1'b0;
   endtask

   function automatic logic [4:0] pick_rd();
      int cands[$];
      for (int i = 1; i < 8; i++) if (m_busy[i]) cands.push_back(i);
      if (cands.size() > 0 && $urandom_range(3, 0) != 0)
         return 5'(cands[$urandom_range(cands.size() - 1, 0)]);
      return 5'($urandom_range(7, 0));
   endfunction

   initial begin
      reset = 1'b1;
      idle_inputs();

      // T1: reset state
      do_reset();
      check("t1_busy", 64'(busy), 64'h0);
      check("t1_we", 64'(we), 64'h0);
      check("t1_wb_err", 64'(wb_err), 64'h0);
      for (int i = 0; i < 4; i++) begin
         issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom); issue_rd = 5'($urandom);
         #1;
         check("t1_issue_ready", 64'(issue_ready), 64'h1);
      end
      idle_inputs();

      // Table-driven hazard checks with r5 and r9 in flight
      tbl[0] = '{5'd0,  5'd0,  5'd0,  1'b1};
      tbl[1] = '{5'd5,  5'd0,  5'd0,  1'b0};
      tbl[2] = '{5'd0,  5'd9,  5'd0,  1'b0};
      tbl[3] = '{5'd0,  5'd0,  5'd5,  1'b0};
      tbl[4] = '{5'd1,  5'd2,  5'd3,  1'b1};
      tbl[5] = '{5'd9,  5'd9,  5'd9,  1'b0};
      tbl[6] = '{5'd0,  5'd0,  5'd31, 1'b1};
      tbl[7] = '{5'd31, 5'd30, 5'd9,  1'b0};
      do_reset();
      issue_one(5'd5);
      issue_one(5'd9);
      check("tbl_busy", 64'(busy), 64'h220);
      for (int i = 0; i < 8; i++) begin
         issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2; issue_rd = tbl[i].rd;
         #1;
         check($sformatf("tbl_ready[%0d]", i), 64'(issue_ready), 64'(tbl[i].exp_ready));
      end
      idle_inputs();

      // T2: RAW hazard through ALU writeback
      do_reset();
      issue_one(5'd5);
      issue_rs1 = 5'd5;
      #1;
      check("t2_ready_blocked", 64'(issue_ready), 64'h0);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      check("t2_alu_ready", 64'(alu_ready), 64'h1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t2_we", 64'(we), 64'h1);
      check("t2_ain", 64'(ain), 64'h5);
      check("t2_din", 64'(din), 64'hDEADBEEF);
      check("t2_ready_still_blocked", 64'(issue_ready), 64'h0);
      tick();
      check("t2_busy_cleared", 64'(busy), 64'h0);
      check("t2_ready_after", 64'(issue_ready), 64'h1);
      check("t2_wb_err", 64'(wb_err), 64'h0);
      idle_inputs();

      // T3: simultaneous requests from reset, ALU first
      do_reset();
      issue_one(5'd3);
      issue_one(5'd4);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
      #1;
      check("t3_alu_first", 64'({alu_ready, mem_ready}), 64'b10);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t3_mem_second", 64'({alu_ready, mem_ready}), 64'b01);
      check("t3_wr1", 64'({we, ain, din}), {26'd0, 1'b1, 5'd3, 32'h11});
      tick();
      mem_valid = 1'b0;
      check("t3_wr2", 64'({we, ain, din}), {26'd0, 1'b1, 5'd4, 32'h22});
      tick();
      check("t3_idle_hold", 64'({we, ain, din}), {26'd0, 1'b0, 5'd4, 32'h22});
      check("t3_wb_err", 64'(wb_err), 64'h0);

      // T4: continuous contention strictly alternates
      do_reset();
      begin
         int a_left = 4;
         int m_left = 4;
         for (int c = 0; c < 8; c++) begin
            logic exp_alu;
            exp_alu = (c % 2 == 0);
            alu_valid = (a_left > 0); alu_rd = 5'd10; alu_data = 32'(c);
            mem_valid = (m_left > 0); mem_rd = 5'd11; mem_data = 32'(100 + c);
            #1;
            check($sformatf("t4_grant[%0d]", c), 64'({alu_ready, mem_ready}),
                  64'({exp_alu, !exp_alu}));
            tick();
            if (exp_alu) a_left--; else m_left--;
            check($sformatf("t4_ain[%0d]", c), 64'(ain), exp_alu ? 64'd10 : 64'd11);
         end
      end
      idle_inputs();

      // T5: rd=0 is inert
      do_reset();
      issue_one(5'd0);
      check("t5_busy", 64'(busy), 64'h0);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      #1;
      check("t5_alu_ready", 64'(alu_ready), 64'h1);
      tick();
      alu_valid = 1'b0;
      check("t5_we", 64'(we), 64'h0);
      check("t5_wb_err", 64'(wb_err), 64'h0);
      tick();
      check("t5_we_later", 64'(we), 64'h0);

      // T6: writeback to a non-busy register is flagged and sticky
      do_reset();
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
      #1;
      check("t6_mem_ready", 64'(mem_ready), 64'h1);
      tick();
      mem_valid = 1'b0;
      check("t6_wr", 64'({we, ain, din}), {26'd0, 1'b1, 5'd7, 32'h77});
      check("t6_err_set", 64'(wb_err), 64'h1);
      tick();
      tick();
      check("t6_err_sticky", 64'(wb_err), 64'h1);
      do_reset();
      check("t6_err_cleared", 64'(wb_err), 64'h0);

      // T7: reset drops a pending write and the scoreboard
      issue_one(5'd9);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      alu_valid = 1'b0;
      check("t7_we_pending", 64'(we), 64'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t7_we_dropped", 64'(we), 64'h0);
      check("t7_busy_dropped", 64'(busy), 64'h0);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      begin
         bit              a_pend = 0, m_pend = 0;
         logic [4:0]      a_rd = '0, m_rd = '0;
         logic [XLEN-1:0] a_dat = '0, m_dat = '0;
         for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(199, 0) == 0) begin
               reset = 1'b1;
               idle_inputs();
               tick();
               reset = 1'b0;
               model_reset();
               a_pend = 0; m_pend = 0;
               check("rnd_reset_busy", 64'(busy), 64'h0);
               continue;
            end
            if (!a_pend && $urandom_range(1, 0) == 1) begin
               a_pend = 1; a_rd = pick_rd(); a_dat = $urandom;
            end
            if (!m_pend && $urandom_range(1, 0) == 1) begin
               m_pend = 1; m_rd = pick_rd(); m_dat = $urandom;
            end
            issue_valid = ($urandom_range(1, 0) == 1);
            issue_rs1 = 5'($urandom_range(7, 0));
            issue_rs2 = 5'($urandom_range(7, 0));
            issue_rd  = 5'($urandom_range(7, 0));
            alu_valid = a_pend; alu_rd = a_rd; alu_data = a_dat;
            mem_valid = m_pend; mem_rd = m_rd; mem_data = m_dat;
            #1;
            begin
               bit exp_ready, alu_wins, mem_wins, any;
               logic [4:0] g_rd;
               logic [XLEN-1:0] g_dat;
               exp_ready = !m_busy[issue_rs1] && !m_busy[issue_rs2] && !m_busy[issue_rd];
               if (a_pend && m_pend) alu_wins = !m_alu_won_last;
               else alu_wins = a_pend;
               mem_wins = m_pend && !alu_wins;
               any = alu_wins || mem_wins;
               check("rnd_issue_ready", 64'(issue_ready), 64'(exp_ready));
               check("rnd_grant", 64'({alu_ready, mem_ready}), 64'({alu_wins, mem_wins}));
               g_rd  = alu_wins ? a_rd  : m_rd;
               g_dat = alu_wins ? a_dat : m_dat;
               tick();
               // Edge: retire the previous write, record the newly issued producer.
               if (any && g_rd != 0 && !m_busy[g_rd]) m_err = 1'b1;
               if (m_we) m_busy[m_ain] = 1'b0;
               if (issue_valid && exp_ready && issue_rd != 0) m_busy[issue_rd] = 1'b1;
               m_we = any && (g_rd != 0);
               if (any) begin
                  m_ain = g_rd; m_din = g_dat; m_alu_won_last = alu_wins;
               end
               if (alu_wins) a_pend = 0;
               if (mem_wins) m_pend = 0;
            end
            check("rnd_wr", 64'({we, ain, din}), 64'({m_we, m_ain, m_din}));
            check("rnd_busy", 64'(busy), 64'(model_busy_vec()));
            check("rnd_wb_err", 64'(wb_err), 64'(m_err));
         end
      end
      idle_inputs();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
